fc_accumulator: RTL and testbench

FC_ACCUMULATOR -- requirements
Module: fc_accumulator

---
 rtl/fc_pkg.sv | 28 ++
 rtl/sat_narrow.sv | 34 +++
 rtl/fc_accumulator.sv | 135 +++++++++++++
 tb/tb_fc_accumulator.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fc_pkg
// Description : Shared widths, FSM state encoding and Q11 constants for the
//               fully-connected layer datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package fc_pkg;

  // Default widths: 16Q11 data words and a 32-bit accumulator on the same Q point
  localparam int FC_DWIDTH = 16;
  localparam int FC_QWIDTH = 11;
  localparam int FC_AWIDTH = 32;

  // Q11 reference constants for 16-bit words
  localparam logic [15:0] ONE  = 16'h0800;
  localparam logic [15:0] MAXV = 16'h7FFF;
  localparam logic [15:0] MINV = 16'h8000;

  // Accumulator control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } fc_state_e;

endpackage : fc_pkg
`default_nettype wire

// File: rtl/sat_narrow.sv
`default_nettype none
// ============================================================================
// Module      : sat_narrow
// Description : Combinational saturating narrowing of a signed word from
//               IWIDTH to OWIDTH bits, with a clamp indication.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_narrow
  import fc_pkg::*;
#(
  parameter int IWIDTH = FC_AWIDTH,
  parameter int OWIDTH = FC_DWIDTH
) (
  input  logic [IWIDTH-1:0] din,
  output logic [OWIDTH-1:0] dout,
  output logic              clamp
);

  // Bits that must all equal the sign bit for the value to fit in OWIDTH
  logic [IWIDTH-OWIDTH:0] upper;

  // Clamp to the most positive/negative OWIDTH value when the upper bits disagree
  always_comb begin
    upper = din[IWIDTH-1:OWIDTH-1];
    clamp = !((&upper) || !(|upper));
    if (clamp) begin
      dout = din[IWIDTH-1] ? {1'b1, {(OWIDTH-1){1'b0}}} : {1'b0, {(OWIDTH-1){1'b1}}};
    end else begin
      dout = din[OWIDTH-1:0];
    end
  end

endmodule : sat_narrow
`default_nettype wire

// File: rtl/fc_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : fc_accumulator
// Description : Streaming dot-product accumulator for a fully-connected layer.
//               Adds a bias and a vector of product beats with saturation,
//               applies optional ReLU and narrows the result to DWIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_accumulator
  import fc_pkg::*;
#(
  parameter int DWIDTH = FC_DWIDTH,
  parameter int QWIDTH = FC_QWIDTH,
  parameter int AWIDTH = FC_AWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_last,
  input  logic [DWIDTH-1:0] bias_in,
  input  logic              relu_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_sat
);

  // The accumulator must be able to hold any data word, and the binary point
  // must sit inside the data word.
  generate
    if (QWIDTH >= DWIDTH || AWIDTH < DWIDTH) begin : g_bad_params
      $error("fc_accumulator: invalid DWIDTH/QWIDTH/AWIDTH combination");
    end
  endgenerate

  fc_state_e         state_q, state_d;
  logic [AWIDTH-1:0] acc_q, acc_d;
  logic              sticky_q, sticky_d;
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic              out_sat_q, out_sat_d;

  logic              beat;
  logic              first_beat;
  logic [AWIDTH-1:0] base;
  logic [AWIDTH:0]   sum_wide;
  logic              add_ovf;
  logic [AWIDTH-1:0] sum_sat;
  logic              sticky_next;
  logic [AWIDTH-1:0] relu_val;
  logic [DWIDTH-1:0] narrow_data;
  logic              narrow_clamp;

  assign in_ready  = (state_q != ST_OUT);
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  // Saturating add of the incoming beat onto bias (first beat) or the running sum
  always_comb begin
    beat       = in_valid && in_ready;
    first_beat = (state_q == ST_IDLE);
    base       = first_beat ? {{(AWIDTH-DWIDTH){bias_in[DWIDTH-1]}}, bias_in} : acc_q;
    sum_wide   = {base[AWIDTH-1], base} + {{(AWIDTH-DWIDTH+1){in_data[DWIDTH-1]}}, in_data};
    add_ovf    = sum_wide[AWIDTH] ^ sum_wide[AWIDTH-1];
    if (add_ovf) begin
      sum_sat = sum_wide[AWIDTH] ? {1'b1, {(AWIDTH-1){1'b0}}} : {1'b0, {(AWIDTH-1){1'b1}}};
    end else begin
      sum_sat = sum_wide[AWIDTH-1:0];
    end
    // A new vector starts with a clean sticky flag
    sticky_next = (first_beat ? 1'b0 : sticky_q) | add_ovf;
    // ReLU zeroing is not a clamp, so it never feeds the saturation flag
    relu_val    = (relu_en && sum_sat[AWIDTH-1]) ? '0 : sum_sat;
  end

  sat_narrow #(
    .IWIDTH (AWIDTH),
    .OWIDTH (DWIDTH)
  ) u_sat_narrow (
    .din   (relu_val),
    .dout  (narrow_data),
    .clamp (narrow_clamp)
  );

  // Next-state logic: accumulate beats, latch the result on in_last, hold it until taken
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    sticky_d   = sticky_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    case (state_q)
      ST_IDLE, ST_ACC: begin
        if (beat) begin
          acc_d    = sum_sat;
          sticky_d = sticky_next;
          if (in_last) begin
            out_data_d = narrow_data;
            out_sat_d  = sticky_next | narrow_clamp;
            state_d    = ST_OUT;
          end else begin
            state_d = ST_ACC;
          end
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops any partial sum and pending result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      sticky_q   <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      sticky_q   <= sticky_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

endmodule : fc_accumulator
`default_nettype wire

// File: tb/tb_fc_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_fc_accumulator
// Description : Self-checking bench for fc_accumulator with a behavioural
//               dot-product reference model and directed + random vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_accumulator;

  localparam int DW = 16;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic [DW-1:0] bias_in;
  logic          relu_en;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sat;

  int checks = 0;
  int errors = 0;

  // Current vector description shared by the driver and the model
  logic [DW-1:0] beats[64];
  int            nbeats;
  logic [DW-1:0] vbias;
  bit            vrelu;

  always #5 clk = ~clk;

  fc_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .bias_in   (bias_in),
    .relu_en   (relu_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  // Reference: exact integer dot product, clamped to the accumulator range after
  // every addition, then ReLU, then clamped to the 16-bit output range.
  function automatic void model_vec(output logic [DW-1:0] d, output bit s);
    longint amax, amin, acc;
    amax = (longint'(1) <<< (AW - 1)) - 1;
    amin = -amax - 1;
    s    = 1'b0;
    acc  = longint'($signed(vbias));
    for (int i = 0; i < nbeats; i++) begin
      acc = acc + longint'($signed(beats[i]));
      if (acc > amax) begin acc = amax; s = 1'b1; end
      if (acc < amin) begin acc = amin; s = 1'b1; end
    end
    if (vrelu && acc < 0) acc = 0;
    if (acc > 32767) begin
      d = 16'h7FFF; s = 1'b1;
    end else if (acc < -32768) begin
      d = 16'h8000; s = 1'b1;
    end else begin
      d = acc[15:0];
    end
  endfunction

  function automatic logic [DW-1:0] rand_word();
    case ($urandom_range(0, 3))
      0: return 16'h7FFF;
      1: return 16'h8000;
      default: return DW'($urandom);
    endcase
  endfunction

  // Drives the current vector; idle gaps up to max_gap cycles between beats.
  // Returns how many cycles out_valid was seen high before the last beat landed.
  task automatic feed_vector(input int max_gap, output int early_valid);
    int w;
    int gap;
    early_valid = 0;
    for (int i = 0; i < nbeats; i++) begin
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        @(posedge clk); #1;
        if (out_valid) early_valid++;
      end
      w = 0;
      while (!in_ready && w < 20) begin
        @(posedge clk); #1;
        w++;
      end
      if (!in_ready) begin
        checks++; errors++;
        $display("FAIL feed_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, w);
        in_valid = 1'b0;
        return;
      end
      if (out_valid) early_valid++;
      in_valid = 1'b1;
      in_data  = beats[i];
      bias_in  = (i == 0) ? vbias : DW'($urandom);
      in_last  = (i == nbeats - 1);
      relu_en  = (i == nbeats - 1) ? vrelu : 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = DW'($urandom);
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    bias_in = '0; relu_en = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h sat=%b, required 0/0000/0", out_valid, out_data, out_sat);
    end
    #3 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    int early;
    vbias = 16'h0800; vrelu = 1'b0; nbeats = 2;
    beats[0] = 16'h0400; beats[1] = 16'h0400;
    feed_vector(0, early);
    checks++;
    if (early != 0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: early=%0d out_valid=%b, required 0/1", early, out_valid);
    end
    checks++;
    if (out_data !== 16'h1000 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: data=%h sat=%b, required 1000/0", out_data, out_sat);
    end
    take_result();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_saturation();
    int early;
    vbias = 16'h0000; vrelu = 1'b0; nbeats = 20;
    for (int i = 0; i < 20; i++) beats[i] = 16'h7FFF;
    feed_vector(0, early);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h7FFF || out_sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_pos: valid=%b data=%h sat=%b, required 1/7fff/1", out_valid, out_data, out_sat);
    end
    take_result();
    nbeats = 3;
    for (int i = 0; i < 3; i++) beats[i] = 16'h8000;
    feed_vector(0, early);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h8000 || out_sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_neg: valid=%b data=%h sat=%b, required 1/8000/1", out_valid, out_data, out_sat);
    end
    take_result();
  endtask

  task automatic test_relu();
    int early;
    vbias = 16'h0000; nbeats = 1; beats[0] = 16'hF800;
    vrelu = 1'b1;
    feed_vector(0, early);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0000 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL relu_on: valid=%b data=%h sat=%b, required 1/0000/0", out_valid, out_data, out_sat);
    end
    take_result();
    vrelu = 1'b0;
    feed_vector(0, early);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hF800 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL relu_off: valid=%b data=%h sat=%b, required 1/f800/0", out_valid, out_data, out_sat);
    end
    take_result();
  endtask

  task automatic test_backpressure();
    int early;
    logic [DW-1:0] exp_d;
    bit exp_s;
    vbias = DW'($urandom); vrelu = 1'($urandom); nbeats = 3;
    for (int i = 0; i < 3; i++) beats[i] = rand_word();
    model_vec(exp_d, exp_s);
    feed_vector(0, early);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_last = 1'b1; in_data = DW'($urandom); bias_in = DW'($urandom);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_d || out_sat !== exp_s) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%b ready=%b data=%h sat=%b, required 1/0/%h/%b",
                 c, out_valid, in_ready, out_data, out_sat, exp_d, exp_s);
      end
      @(posedge clk); #1;
    end
    take_result();
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: out_valid=%b, required 0", out_valid);
    end
    vbias = DW'($urandom); vrelu = 1'b0; nbeats = 2;
    beats[0] = DW'($urandom); beats[1] = DW'($urandom);
    model_vec(exp_d, exp_s);
    feed_vector(0, early);
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_d || out_sat !== exp_s) begin
      errors++;
      $display("FAIL hold_next: valid=%b data=%h sat=%b, required 1/%h/%b", out_valid, out_data, out_sat, exp_d, exp_s);
    end
    take_result();
  endtask

  task automatic test_back_to_back();
    localparam int N = 8;
    logic [DW-1:0] qd[$];
    bit            qs[$];
    logic [DW-1:0] d;
    bit            s;
    int issued = 0;
    int got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 2 * N; c++) begin
      checks++;
      if (out_valid !== (c % 2 == 1)) begin
        errors++;
        $display("FAIL b2b_cadence_c%0d: out_valid=%b, required %0b", c, out_valid, (c % 2 == 1));
      end
      if (out_valid && qd.size() > 0) begin
        d = qd.pop_front(); s = qs.pop_front(); got++;
        checks++;
        if (out_data !== d || out_sat !== s) begin
          errors++;
          $display("FAIL b2b_result%0d: data=%h sat=%b, required %h/%b", got, out_data, out_sat, d, s);
        end
      end
      if (in_ready && issued < N) begin
        vbias = rand_word(); vrelu = 1'b0; nbeats = 1; beats[0] = rand_word();
        model_vec(d, s);
        qd.push_back(d); qs.push_back(s);
        in_valid = 1'b1; in_last = 1'b1; in_data = beats[0]; bias_in = vbias; relu_en = 1'b0;
        issued++;
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    checks++;
    if (got != N) begin
      errors++;
      $display("FAIL b2b_count: results=%0d, required %0d", got, N);
    end
  endtask

  task automatic test_reset_midvector();
    int early;
    // Two of four beats, then an asynchronous reset between clock edges
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_last = 1'b0; in_data = 16'h1234; bias_in = 16'h0100;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_async_mid: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
    end
    @(posedge clk); #3 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_spurious_c%0d: out_valid=%b, required 0", c, out_valid);
      end
    end
    vbias = 16'h0000; vrelu = 1'b0; nbeats = 1; beats[0] = 16'h0800;
    feed_vector(0, early);
    checks++;
    if (early != 0 || out_valid !== 1'b1 || out_data !== 16'h0800 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL rst_fresh: early=%0d valid=%b data=%h sat=%b, required 0/1/0800/0",
               early, out_valid, out_data, out_sat);
    end
    // Reset while a result is pending discards it
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
      errors++;
      $display("FAIL rst_in_out: valid=%b data=%h, required 0/0000", out_valid, out_data);
    end
    @(posedge clk); #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_out_after: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_random();
    int early;
    logic [DW-1:0] exp_d;
    bit exp_s;
    for (int v = 0; v < 40; v++) begin
      nbeats = $urandom_range(1, 8);
      vbias  = rand_word();
      vrelu  = 1'($urandom);
      for (int i = 0; i < nbeats; i++) beats[i] = rand_word();
      model_vec(exp_d, exp_s);
      feed_vector(2, early);
      checks++;
      if (early != 0 || out_valid !== 1'b1 || out_data !== exp_d || out_sat !== exp_s) begin
        errors++;
        $display("FAIL rand_vec%0d: early=%0d valid=%b data=%h sat=%b, required 0/1/%h/%b",
                 v, early, out_valid, out_data, out_sat, exp_d, exp_s);
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d) begin
        errors++;
        $display("FAIL rand_hold%0d: valid=%b data=%h, required 1/%h", v, out_valid, out_data, exp_d);
      end
      take_result();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_relu();
    test_backpressure();
    test_back_to_back();
    test_reset_midvector();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fc_accumulator
`default_nettype wire
